raster_dispatch: RTL
====================

# raster_dispatch

Triangle scheduler between triangle setup and a bank of `NUM_UNITS` rasterizer backend instances. Buffers setup descriptors in a small FIFO and issues each one to an idle backend using round-robin selection. Enforces frame ordering: no triangle of frame N+1 is issued until every triangle of frame N has reported done. Emits a single frame-done pulse, which replaces the per-backend `finished` output (backend `i_last` inputs are tied low at top level).

## Interface

Parameters:
- `PAYLOADWIDTH`, 256: width of one opaque triangle descriptor (bounding box, edge values, deltas, z, id), passed through unmodified.
- `NUM_UNITS`, 2: number of rasterizer backends; range 1–8.
- `FIFO_DEPTH`, 4: descriptor FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `i_payload` in PAYLOADWIDTH: descriptor from setup.
- `i_dv` in 1: descriptor valid.
- `i_last` in 1: descriptor is the last triangle of the frame.
- `o_ready` out 1: FIFO can accept a descriptor.
- `o_unit_payload` out NUM_UNITS*PAYLOADWIDTH: per-unit descriptor. Unit k occupies bits [k*PAYLOADWIDTH +: PAYLOADWIDTH].
- `o_unit_dv` out NUM_UNITS: per-unit one-cycle issue strobe (drives backend `i_dv`).
- `i_unit_ready` in NUM_UNITS: backend `ready`.
- `i_unit_done` in NUM_UNITS: backend `done` pulse.
- `o_unit_busy` out NUM_UNITS: per-unit outstanding flag.
- `o_frame_done` out 1: one-cycle frame-complete pulse.
- `o_tri_count` out 16: triangles issued in the current frame.

## Operation

**Input FIFO**
- Each entry holds {payload, last}.
- `o_ready` = !full (combinational from registered pointers).
- A write occurs when `i_dv && o_ready`. `i_dv` while full is ignored; setup must hold the descriptor.

**Busy tracking**
- `busy[k]` is set on issue to unit k and cleared on `i_unit_done[k]`.
- Backend `ready` deasserts combinationally on its `i_dv`, so unit k is eligible only when `!busy[k] && i_unit_ready[k]`.
- `i_unit_done[k]` while `busy[k]==0` is ignored.

**Issue**
- At most one descriptor issues per cycle.
- Search starts at `rr_ptr`, wraps modulo NUM_UNITS, and takes the first eligible unit.
- On issue: FIFO pops; `o_unit_payload[k]` is loaded (held until the next issue to k); `o_unit_dv[k]`=1 for exactly one cycle; `busy[k]` is set; `rr_ptr` becomes k+1 (wraps).

**State machine (FSM)**
- `RUN`: issue while FIFO non-empty and a unit is eligible. Issuing an entry with last=1 moves to `DRAIN`.
- `DRAIN`: no issue. When all `busy` flags are clear, go to `FLUSH`.
- `FLUSH`: `o_frame_done`=1 for one cycle; `o_tri_count` clears; return to `RUN`.
- FIFO writes continue in all states.

**Triangle counter**
- `o_tri_count` increments per issue and saturates at 0xFFFF.
- `FLUSH` clears it. If an issue and a clear coincide, the clear wins; issue cannot occur in `FLUSH` anyway.

**Boundary conditions**
- A done on unit j in the same cycle as an issue to unit k≠j: both take effect.
- An issue and a done can never target the same unit in the same cycle.
- FIFO write and pop in the same cycle: allowed, occupancy unchanged. When full, a write is impossible in that cycle.
- A last=1 entry issued with all other units idle: `DRAIN` waits for its done.
- Reset mid-frame: FIFO empties, busy flags clear, `rr_ptr` returns to 0, FSM returns to `RUN`. Any backend work in flight is abandoned; the backends share `rstn`.

## Timing

Reset values:
- `o_ready`=1, `o_unit_dv`=0, `o_unit_payload`=0, `o_unit_busy`=0, `o_frame_done`=0, `o_tri_count`=0.

Latency and throughput:
- Descriptor accepted at edge t into an empty FIFO with an eligible unit: `o_unit_dv` is high during cycle t+1. Issue is registered from FIFO head state.
- `busy[k]` is visible the cycle after the issue edge, i.e. during the same cycle `o_unit_dv[k]` is high.
- Back-to-back issue to different units in consecutive cycles is supported.
- Last `i_unit_done` sampled at edge t with FSM in `DRAIN`: `DRAIN` evaluates the cleared busy flags in cycle t+1; `FLUSH` is entered at edge t+2. `o_frame_done` is high during cycle t+2.
- All outputs are registered except `o_ready`.

## Test plan

- **Single triangle, single unit.** NUM_UNITS=2; send one descriptor with last=1 into idle units.
  - `o_unit_dv[0]` is high one cycle after acceptance; `o_unit_busy`=01.
  - Pulse done[0]: `o_frame_done` is high exactly one cycle.
  - `o_tri_count` reads 1, then 0.
- **Round-robin.** Send 4 descriptors; units return done immediately.
  - Issue order is units 0, 1, 0, 1.
  - With unit 0 held busy: descriptors 2 and 3 go to unit 1 only, serialized on its done.
- **Backpressure.** Both units stalled; write 5 descriptors.
  - The 5th stalls with `o_ready`=0 after 4 accepts.
  - Release done[0]: `o_ready` returns to 1 the cycle after the pop.
- **Frame barrier.** Frame A = 2 triangles (second has last=1), followed by frame B's first descriptor.
  - B is not issued until both A dones arrive and `o_frame_done` pulses.
  - B issues the cycle after `FLUSH`.
- **Spurious and simultaneous events.**
  - done[1] with unit 1 idle: no state change.
  - done[0] coinciding with an issue to unit 1: both busy updates applied.
- **Async reset.** Assert `rstn`=0 mid-`DRAIN` between clock edges.
  - All outputs go to reset values immediately.
  - After release, a new descriptor issues to unit 0.

Source files
------------

// File: rtl/raster_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : raster_dispatch                                                 |
// | Purpose  : Triangle scheduler between triangle setup and a bank of         |
// |            rasterizer backends. Buffers setup descriptors in a FIFO,       |
// |            issues each one to an idle backend chosen round-robin, keeps    |
// |            frames ordered and emits one frame-done pulse per frame.        |
// | Ports    : clk, rstn (async, active-low)                                   |
// |            i_payload/i_dv/i_last/o_ready  : descriptor input from setup    |
// |            o_unit_payload/o_unit_dv       : per-unit descriptor + strobe   |
// |            i_unit_ready/i_unit_done       : per-unit backend handshakes    |
// |            o_unit_busy                    : per-unit outstanding flag      |
// |            o_frame_done                   : one-cycle frame-complete pulse |
// |            o_tri_count                    : triangles issued this frame    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module raster_dispatch #(
  parameter int PAYLOADWIDTH = 256,
  parameter int NUM_UNITS    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [PAYLOADWIDTH-1:0]           i_payload,
  input  logic                              i_dv,
  input  logic                              i_last,
  output logic                              o_ready,
  output logic [NUM_UNITS*PAYLOADWIDTH-1:0] o_unit_payload,
  output logic [NUM_UNITS-1:0]              o_unit_dv,
  input  logic [NUM_UNITS-1:0]              i_unit_ready,
  input  logic [NUM_UNITS-1:0]              i_unit_done,
  output logic [NUM_UNITS-1:0]              o_unit_busy,
  output logic                              o_frame_done,
  output logic [15:0]                       o_tri_count
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int c_EW = PAYLOADWIDTH + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  // FIFO storage: each entry is {payload, last}
  logic [c_EW-1:0]         r_mem [FIFO_DEPTH];
  logic [c_AW:0]           r_wr_ptr;
  logic [c_AW:0]           r_rd_ptr;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_wr;
  logic [c_EW-1:0]         w_head;
  logic                    w_head_valid;

  logic [NUM_UNITS-1:0]    r_busy;
  logic [NUM_UNITS-1:0]    r_unit_dv;
  logic [PAYLOADWIDTH-1:0] r_payload [NUM_UNITS];
  logic [c_PW-1:0]         r_rr;
  logic [15:0]             r_count;
  logic                    r_frame_done;

  logic [NUM_UNITS-1:0]    w_elig;
  logic                    w_found;
  logic [c_PW-1:0]         w_sel;
  logic                    w_issue;
  logic [NUM_UNITS-1:0]    w_issue_vec;

  // --------------------------------------------------------------------------
  // Input FIFO (extra pointer bit distinguishes full from empty)
  // --------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_ready = !w_full;
  assign w_wr    = i_dv && !w_full;

  // An empty FIFO forwards the incoming descriptor so it can issue on the
  // same edge it is written; both pointers then advance together.
  assign w_head       = w_empty ? {i_payload, i_last} : r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_head_valid = !w_empty || w_wr;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {i_payload, i_last};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin unit selection
  // A backend drops ready on the same cycle it sees its strobe, so the busy
  // flag is what keeps a unit from being chosen twice in a row.
  // --------------------------------------------------------------------------
  assign w_elig = ~r_busy & i_unit_ready;

  // For each possible pointer value the rotated unit index is a constant;
  // the downward offset loop leaves the lowest offset (nearest unit) selected.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int r = 0; r < NUM_UNITS; r++) begin
      if (r_rr == c_PW'(r)) begin
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
          if (w_elig[(r + i) % NUM_UNITS]) begin
            w_found = 1'b1;
            w_sel   = c_PW'((r + i) % NUM_UNITS);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame-ordering state machine
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      RUN: begin
        w_issue = w_head_valid && w_found;
        if (w_issue && w_head[0]) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (r_busy == '0) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= RUN;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= (w_state_nxt == FLUSH);
    end
  end

  // --------------------------------------------------------------------------
  // Per-unit issue registers
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
    assign w_issue_vec[k] = w_issue && (w_sel == c_PW'(k));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_payload[k] <= '0;
      end else if (w_issue_vec[k]) begin
        r_payload[k] <= w_head[c_EW-1:1];
      end
    end

    assign o_unit_payload[k*PAYLOADWIDTH +: PAYLOADWIDTH] = r_payload[k];
  end

  // A done never targets the unit being issued to on the same edge, so the
  // clear and set terms never collide.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy    <= '0;
      r_unit_dv <= '0;
      r_rr      <= '0;
    end else begin
      r_busy    <= (r_busy & ~i_unit_done) | w_issue_vec;
      r_unit_dv <= w_issue_vec;
      if (w_issue) begin
        r_rr <= (w_sel == c_PW'(NUM_UNITS - 1)) ? '0 : w_sel + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-frame triangle counter (saturating; cleared as FLUSH completes)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (r_state == FLUSH) begin
      r_count <= '0;
    end else if (w_issue && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_unit_dv    = r_unit_dv;
  assign o_unit_busy  = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_tri_count  = r_count;

endmodule
`default_nettype wire
